// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// store_buffer : in-order store FIFO between core and data RAM, with
//                byte-granular youngest-wins forwarding onto load data.
// Revision     : 1.0
// ============================================================================
module store_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adr_v_i,
  input  logic [XLEN-1:0]   adr_i,
  input  logic              is_store_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [2:0]        access_size_i,
  output logic [XLEN-1:0]   load_data_o,
  output logic [XLEN-1:0]   mem_rd_adr_o,
  input  logic [XLEN-1:0]   mem_rd_data_i,
  output logic              mem_wr_v_o,
  input  logic              mem_wr_ready_i,
  output logic [XLEN-1:0]   mem_wr_adr_o,
  output logic [XLEN-1:0]   mem_wr_data_o,
  output logic [XLEN/8-1:0] mem_wr_strb_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              misaligned_o,
  output logic              overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int NB    = XLEN / 8;
  localparam int WA_W  = XLEN - 2;
  localparam logic [PTR_W:0]   c_depth   = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]   c_cnt_one = 1;
  localparam logic [PTR_W-1:0] c_ptr_one = 1;

  logic [WA_W-1:0]  r_adr  [DEPTH];
  logic [XLEN-1:0]  r_data [DEPTH];
  logic [NB-1:0]    r_strb [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic             r_misaligned;
  logic             r_overflow;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_illegal;
  logic             w_cross;
  logic [3:0]       w_base;
  logic [7:0]       w_mask_wide;
  logic [XLEN-1:0]  w_shift_data;
  logic [XLEN-1:0]  w_fwd;
  logic [PTR_W-1:0] w_idx;

  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == '0);
  assign full_o  = w_full;
  assign empty_o = w_empty;

  // Masking with reset keeps a queued write from handshaking in the reset cycle.
  assign mem_wr_v_o    = !w_empty && !reset;
  assign w_pop         = mem_wr_v_o && mem_wr_ready_i;
  assign w_push        = adr_v_i && is_store_i && (!w_full || w_pop);
  assign mem_wr_adr_o  = {r_adr[r_head], 2'b00};
  assign mem_wr_data_o = r_data[r_head];
  assign mem_wr_strb_o = r_strb[r_head];
  assign mem_rd_adr_o  = {adr_i[XLEN-1:2], 2'b00};

  always_comb begin
    w_base = 4'b0000;
    case (access_size_i)
      3'b000:  w_base = 4'b0001;
      3'b001:  w_base = 4'b0011;
      3'b010:  w_base = 4'b1111;
      default: w_base = 4'b0000;
    endcase
  end

  assign w_mask_wide  = {4'b0000, w_base} << adr_i[1:0];
  assign w_cross      = |w_mask_wide[7:4];
  assign w_illegal    = access_size_i[2] || (&access_size_i[1:0]);
  assign w_shift_data = store_data_i << {adr_i[1:0], 3'b000};

  // Walk entries oldest to youngest so the youngest matching byte lands last.
  always_comb begin
    w_fwd = mem_rd_data_i;
    w_idx = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + i[PTR_W-1:0];
      if (r_valid[w_idx] && (r_adr[w_idx] == adr_i[XLEN-1:2])) begin
        for (int b = 0; b < NB; b++) begin
          if (r_strb[w_idx][b]) begin
            w_fwd[8*b +: 8] = r_data[w_idx][8*b +: 8];
          end
        end
      end
    end
  end

  assign load_data_o  = (adr_v_i && !is_store_i) ? w_fwd : mem_rd_data_i;
  assign misaligned_o = r_misaligned;
  assign overflow_o   = r_overflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_misaligned <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + c_ptr_one;
      end
      // When full, tail aliases the popped head; the push must win that slot.
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
      r_misaligned <= adr_v_i && (w_cross || w_illegal);
      if (adr_v_i && is_store_i && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_adr[r_tail]  <= adr_i[XLEN-1:2];
      r_data[r_tail] <= w_shift_data;
      r_strb[r_tail] <= w_mask_wide[3:0];
    end
  end

  a_no_push_beyond_depth: assert property (@(posedge clk) disable iff (reset)
    !(w_push && !w_pop && w_full));
  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (reset)
    !(w_pop && w_empty));

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// tb_store_buffer : vector table, directed corner sequences and a randomized
// run checked against a queue-based reference model.
module tb_store_buffer;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        adr_v_i;
  logic [31:0] adr_i;
  logic        is_store_i;
  logic [31:0] store_data_i;
  logic [2:0]  access_size_i;
  logic [31:0] load_data_o;
  logic [31:0] mem_rd_adr_o;
  logic [31:0] mem_rd_data_i;
  logic        mem_wr_v_o;
  logic        mem_wr_ready_i;
  logic [31:0] mem_wr_adr_o;
  logic [31:0] mem_wr_data_o;
  logic [3:0]  mem_wr_strb_o;
  logic        full_o;
  logic        empty_o;
  logic        misaligned_o;
  logic        overflow_o;

  always #5 clk = ~clk;

  store_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .adr_v_i(adr_v_i), .adr_i(adr_i),
    .is_store_i(is_store_i), .store_data_i(store_data_i),
    .access_size_i(access_size_i), .load_data_o(load_data_o),
    .mem_rd_adr_o(mem_rd_adr_o), .mem_rd_data_i(mem_rd_data_i),
    .mem_wr_v_o(mem_wr_v_o), .mem_wr_ready_i(mem_wr_ready_i),
    .mem_wr_adr_o(mem_wr_adr_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_wr_strb_o(mem_wr_strb_o), .full_o(full_o), .empty_o(empty_o),
    .misaligned_o(misaligned_o), .overflow_o(overflow_o)
  );

  typedef struct {
    logic [31:0] adr;
    logic [2:0]  sz;
    logic [31:0] sd;
    logic [3:0]  strb;
    logic [31:0] data;
    logic        mis;
  } vec_t;

  typedef struct {
    logic [29:0] wa;
    logic [31:0] data;
    logic [3:0]  strb;
  } ent_t;

  vec_t vt [7];
  ent_t q [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic        rv, rst_st, rrdy, m_pop, m_full, m_mis, m_ovf;
  logic [31:0] ra, rsd, rrd;
  logic [2:0]  rsz;
  int          nb, off, m;
  ent_t        e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic st, input logic [31:0] a,
                       input logic [31:0] sd, input logic [2:0] sz,
                       input logic [31:0] rd, input logic rdy);
    adr_v_i = v; is_store_i = st; adr_i = a; store_data_i = sd;
    access_size_i = sz; mem_rd_data_i = rd; mem_wr_ready_i = rdy;
    #1;
  endtask

  task automatic reset_dut;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    tick;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] r;
    r = rd;
    foreach (q[k]) begin
      if (q[k].wa == a[31:2]) begin
        for (int b = 0; b < 4; b++) begin
          if (q[k].strb[b]) r[8*b +: 8] = q[k].data[8*b +: 8];
        end
      end
    end
    return r;
  endfunction

  initial begin
    vt[0] = '{32'h100, 3'd2, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 1'b0};
    vt[1] = '{32'h101, 3'd0, 32'h123456AA, 4'b0010, 32'h3456AA00, 1'b0};
    vt[2] = '{32'h102, 3'd1, 32'h0000BBCC, 4'b1100, 32'hBBCC0000, 1'b0};
    vt[3] = '{32'h103, 3'd1, 32'h00001234, 4'b1000, 32'h34000000, 1'b1};
    vt[4] = '{32'h102, 3'd2, 32'h11223344, 4'b1100, 32'h33440000, 1'b1};
    vt[5] = '{32'h103, 3'd0, 32'h00000055, 4'b1000, 32'h55000000, 1'b0};
    vt[6] = '{32'h101, 3'd1, 32'h00006677, 4'b0110, 32'h00667700, 1'b0};

    reset_dut;
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_wr_v", mem_wr_v_o, 0);
    chk("rst_mis", misaligned_o, 0);
    chk("rst_ovf", overflow_o, 0);

    // Store then forwarded load while RAM write is stalled
    drive(1, 1, 32'h100, 32'hDEADBEEF, 3'd2, 0, 0);
    tick;
    drive(1, 0, 32'h100, 0, 3'd2, 32'h11111111, 0);
    chk("fwd_word", load_data_o, 32'hDEADBEEF);
    chk("fwd_rd_adr", mem_rd_adr_o, 32'h100);
    chk("fwd_wr_v", mem_wr_v_o, 1);
    chk("fwd_strb", mem_wr_strb_o, 4'b1111);
    chk("fwd_empty", empty_o, 0);

    // Byte + half merge, then in-order drain
    reset_dut;
    drive(1, 1, 32'h101, 32'h000000AA, 3'd0, 0, 0);
    tick;
    drive(1, 1, 32'h102, 32'h0000BBCC, 3'd1, 0, 0);
    tick;
    drive(1, 0, 32'h100, 0, 3'd2, 32'h00000000, 0);
    chk("merge_load", load_data_o, 32'hBBCCAA00);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("drain0_strb", mem_wr_strb_o, 4'b0010);
    tick;
    chk("drain1_strb", mem_wr_strb_o, 4'b1100);
    tick;
    chk("drain_empty", empty_o, 1);

    // Strobe/data/misalignment table
    foreach (vt[i]) begin
      drive(1, 1, vt[i].adr, vt[i].sd, vt[i].sz, 0, 0);
      tick;
      chk($sformatf("vt%0d_strb", i), mem_wr_strb_o, vt[i].strb);
      chk($sformatf("vt%0d_data", i), mem_wr_data_o, vt[i].data);
      chk($sformatf("vt%0d_adr", i), mem_wr_adr_o, 32'h100);
      chk($sformatf("vt%0d_mis", i), misaligned_o, vt[i].mis);
      drive(0, 0, 0, 0, 0, 0, 1);
      tick;
      chk($sformatf("vt%0d_mis_clr", i), misaligned_o, 0);
      chk($sformatf("vt%0d_empty", i), empty_o, 1);
    end
    drive(1, 0, 32'h100, 0, 3'd3, 0, 0);
    tick;
    chk("illegal_mis", misaligned_o, 1);
    drive(1, 0, 32'h103, 0, 3'd1, 0, 0);
    tick;
    chk("ld_cross_mis", misaligned_o, 1);

    // Full + simultaneous push/pop across pointer wrap
    reset_dut;
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 32'h200 + 32'(4 * k), 32'h10 + 32'(k), 3'd2, 0, 0);
      tick;
    end
    chk("pp_full", full_o, 1);
    drive(1, 1, 32'h210, 32'h55, 3'd2, 0, 1);
    chk("pp_head_pre", mem_wr_adr_o, 32'h200);
    tick;
    chk("pp_full_after", full_o, 1);
    chk("pp_ovf", overflow_o, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("pp_order%0d", k), mem_wr_data_o, (k < 3) ? 32'h11 + 32'(k) : 32'h55);
      tick;
    end
    chk("pp_empty", empty_o, 1);

    // Overflow: fifth store dropped, flag sticky through drain
    reset_dut;
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 32'h200 + 32'(4 * k), 32'(k + 1), 3'd2, 0, 0);
      tick;
    end
    chk("ov_full", full_o, 1);
    drive(1, 1, 32'h300, 32'h99, 3'd2, 0, 0);
    tick;
    chk("ov_flag", overflow_o, 1);
    chk("ov_head", mem_wr_adr_o, 32'h200);
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ov_pop%0d", k), mem_wr_data_o, 32'(k + 1));
      tick;
    end
    chk("ov_empty", empty_o, 1);
    chk("ov_sticky", overflow_o, 1);

    // Reset during drain discards everything
    drive(1, 1, 32'h100, 32'hAAAA0001, 3'd2, 0, 0);
    tick;
    drive(1, 1, 32'h100, 32'hAAAA0002, 3'd2, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 1);
    tick;
    reset = 1'b1;
    #1;
    chk("mid_rst_wr_v", mem_wr_v_o, 0);
    tick;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("mid_rst_empty", empty_o, 1);
    chk("mid_rst_wr_v2", mem_wr_v_o, 0);
    chk("mid_rst_ovf", overflow_o, 0);
    drive(1, 0, 32'h100, 0, 3'd2, 32'hCAFEF00D, 1);
    chk("mid_rst_load", load_data_o, 32'hCAFEF00D);

    // Randomized traffic against the queue model
    reset_dut;
    q.delete();
    m_ovf = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rv = ($urandom_range(0, 3) != 0);
      rst_st = $urandom_range(0, 1) == 1;
      ra = 32'h100 + 32'($urandom_range(0, 15));
      rsz = 3'($urandom_range(0, 2));
      rsd = $urandom;
      rrd = $urandom;
      rrdy = ($urandom_range(0, 2) == 0);
      drive(rv, rst_st, ra, rsd, rsz, rrd, rrdy);
      chk("r_empty", empty_o, q.size() == 0);
      chk("r_full", full_o, q.size() == DEPTH);
      chk("r_wr_v", mem_wr_v_o, q.size() != 0);
      chk("r_rd_adr", mem_rd_adr_o, {ra[31:2], 2'b00});
      if (q.size() != 0) begin
        chk("r_wr_adr", mem_wr_adr_o, {q[0].wa, 2'b00});
        chk("r_wr_data", mem_wr_data_o, q[0].data);
        chk("r_wr_strb", mem_wr_strb_o, q[0].strb);
      end
      if (rv && !rst_st) chk("r_load", load_data_o, ref_load(ra, rrd));
      nb = 1 << rsz;
      off = int'(ra[1:0]);
      m = ((1 << nb) - 1) << off;
      m_mis = rv && (m > 15);
      m_pop = (q.size() != 0) && rrdy;
      m_full = (q.size() == DEPTH);
      if (m_pop) void'(q.pop_front());
      if (rv && rst_st) begin
        if (!m_full || m_pop) begin
          e.wa = ra[31:2];
          e.data = rsd << (8 * off);
          e.strb = m[3:0];
          q.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
      tick;
      chk("r_mis", misaligned_o, m_mis);
      chk("r_ovf", overflow_o, m_ovf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
